// File: rtl/qam_sym_feeder_if.sv
// qam_sym_feeder_if: groups the byte-stream, symbol-stream and config/status
// signals of the QAM symbol feeder. The slave modport is the feeder's view and
// the master modport is the view of whoever drives it (framer/mapper/bench).
interface qam_sym_feeder_if;
    logic       i_start;
    logic [2:0] i_conf_qam_num;
    logic       i_conf_qam_gray;
    logic [7:0] i_byte_data;
    logic       i_byte_val;
    logic       i_byte_last;
    logic       o_byte_ready;
    logic       i_mod_ready;
    logic [7:0] o_sym_data;
    logic       o_sym_val;
    logic [2:0] o_conf_qam_num;
    logic       o_conf_qam_gray;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    modport slave (
        input  i_start,
        input  i_conf_qam_num,
        input  i_conf_qam_gray,
        input  i_byte_data,
        input  i_byte_val,
        input  i_byte_last,
        output o_byte_ready,
        input  i_mod_ready,
        output o_sym_data,
        output o_sym_val,
        output o_conf_qam_num,
        output o_conf_qam_gray,
        output o_busy,
        output o_frame_done,
        output o_err
    );

    modport master (
        output i_start,
        output i_conf_qam_num,
        output i_conf_qam_gray,
        output i_byte_data,
        output i_byte_val,
        output i_byte_last,
        input  o_byte_ready,
        output i_mod_ready,
        input  o_sym_data,
        input  o_sym_val,
        input  o_conf_qam_num,
        input  o_conf_qam_gray,
        input  o_busy,
        input  o_frame_done,
        input  o_err
    );
endinterface

// File: rtl/qam_sym_feeder.sv
// qam_sym_feeder: repacks a framed byte stream into 1/2/4/6/8-bit symbol
// groups for the QAM mapper, one symbol per cycle under downstream ready.
// Optional feature macro: QAM_SYM_FEED_PAD_EN -- when defined, residual bits
// at frame end are sent as one zero-padded symbol; when undefined they are
// dropped and the loss is flagged on o_err together with o_frame_done.
module qam_sym_feeder #(
    parameter int BUF_W = 16
) (
    input  logic             clk,
    input  logic             xrst,
    qam_sym_feeder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [BUF_W-1:0] r_bitBuf;
    logic [BUF_W-1:0] w_bitBufNext;
    logic [4:0]       r_bitCount;
    logic [4:0]       w_bitCountNext;
    logic [2:0]       r_qamNum;
    logic             r_qamGray;
    logic             r_symVal;
    logic [7:0]       r_symData;
    logic             r_err;

    logic [3:0]       w_bps;
    logic [4:0]       w_bpsWide;
    logic             w_active;
    logic             w_haveFull;
    logic             w_residual;
    logic             w_padEmit;
    logic             w_discard;
    logic             w_emit;
    logic             w_byteReady;
    logic             w_accept;
    logic             w_goodStart;
    logic             w_badStart;
    logic [4:0]       w_symShift;
    logic [BUF_W-1:0] w_symWide;
    logic [7:0]       w_sym;
    logic [BUF_W-1:0] w_bufShifted;
    logic [4:0]       w_cntAfter;
    logic [BUF_W-1:0] w_byteAligned;
    logic [BUF_W-1:0] w_bufIns;

    // Bits per symbol for the latched modulation order.
    always_comb begin
        w_bps = 4'd8;
        case (r_qamNum)
            3'd0:    w_bps = 4'd1;
            3'd1:    w_bps = 4'd2;
            3'd2:    w_bps = 4'd4;
            3'd3:    w_bps = 4'd6;
            default: w_bps = 4'd8;
        endcase
    end

    assign w_bpsWide   = {1'b0, w_bps};
    assign w_active    = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign w_haveFull  = (r_bitCount >= w_bpsWide);
    assign w_residual  = (r_state == ST_FLUSH) && !w_haveFull && (r_bitCount != 5'd0);

`ifdef QAM_SYM_FEED_PAD_EN
    assign w_padEmit   = w_residual && bus.i_mod_ready;
    assign w_discard   = 1'b0;
`else
    assign w_padEmit   = 1'b0;
    assign w_discard   = w_residual;
`endif

    assign w_emit      = (w_active && w_haveFull && bus.i_mod_ready) || w_padEmit;
    assign w_byteReady = (r_state == ST_RUN) && (r_bitCount <= 5'd8);
    assign w_accept    = w_byteReady && bus.i_byte_val;
    assign w_goodStart = (r_state == ST_IDLE) && bus.i_start && (bus.i_conf_qam_num <= 3'd4);
    assign w_badStart  = (r_state == ST_IDLE) && bus.i_start && (bus.i_conf_qam_num > 3'd4);

    // The buffer is left-aligned with zeros below the valid bits, so taking the
    // top bps bits also yields the zero padding for a residual symbol.
    assign w_symShift    = 5'(BUF_W) - w_bpsWide;
    assign w_symWide     = r_bitBuf >> w_symShift;
    assign w_sym         = w_symWide[7:0];
    assign w_bufShifted  = w_emit ? (r_bitBuf << w_bps) : r_bitBuf;
    assign w_cntAfter    = w_emit ? (w_padEmit ? 5'd0 : (r_bitCount - w_bpsWide)) : r_bitCount;
    assign w_byteAligned = {bus.i_byte_data, {(BUF_W-8){1'b0}}};
    assign w_bufIns      = w_byteAligned >> w_cntAfter;

    // Next buffer contents: drop emitted bits, then append an accepted byte
    // just below the bits that remain.
    always_comb begin
        w_bitBufNext   = w_bufShifted;
        w_bitCountNext = w_cntAfter;
        if (w_accept) begin
            w_bitBufNext   = w_bufShifted | w_bufIns;
            w_bitCountNext = w_cntAfter + 5'd8;
        end
        if (r_state == ST_DONE) begin
            w_bitBufNext   = '0;
            w_bitCountNext = 5'd0;
        end
    end

    // Frame sequencing: start, last-byte acceptance, drain and completion.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_goodStart) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && bus.i_byte_last) begin
                    w_stateNext = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!w_haveFull) begin
                    if (r_bitCount == 5'd0) begin
                        w_stateNext = ST_DONE;
                    end else if (w_padEmit || w_discard) begin
                        w_stateNext = ST_DONE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State, bit buffer and bit count.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state    <= ST_IDLE;
            r_bitBuf   <= '0;
            r_bitCount <= 5'd0;
        end else begin
            r_state    <= w_stateNext;
            r_bitBuf   <= w_bitBufNext;
            r_bitCount <= w_bitCountNext;
        end
    end

    // Modulation config is captured only on an accepted start and held after.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_qamNum  <= 3'd0;
            r_qamGray <= 1'b0;
        end else if (w_goodStart) begin
            r_qamNum  <= bus.i_conf_qam_num;
            r_qamGray <= bus.i_conf_qam_gray;
        end
    end

    // Registered symbol output; data is forced to zero when not valid.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_symVal  <= 1'b0;
            r_symData <= 8'd0;
        end else begin
            r_symVal  <= w_emit;
            r_symData <= w_emit ? w_sym : 8'd0;
        end
    end

    // Error pulse: bad start config, or residual bits dropped (lands in DONE).
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_badStart || w_discard;
        end
    end

    assign bus.o_byte_ready    = w_byteReady;
    assign bus.o_sym_data      = r_symData;
    assign bus.o_sym_val       = r_symVal;
    assign bus.o_conf_qam_num  = r_qamNum;
    assign bus.o_conf_qam_gray = r_qamGray;
    assign bus.o_busy          = (r_state != ST_IDLE);
    assign bus.o_frame_done    = (r_state == ST_DONE);
    assign bus.o_err           = r_err;

endmodule

// File: tb/tb_qam_sym_feeder.sv
// tb_qam_sym_feeder: directed bench for qam_sym_feeder. A bit-level model
// turns every driven byte into expected symbols on a queue; a monitor pops
// and compares each symbol the DUT produces.
module tb_qam_sym_feeder;

    logic clk;
    logic xrst;

    qam_sym_feeder_if bus ();

    qam_sym_feeder dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    bit        mBits[$];
    logic [7:0] expQ[$];
    int        curBps = 1;
    int        modMode = 0;
    int        stalls = 0;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = never ready.
    initial begin
        bus.i_mod_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (modMode)
                1:       bus.i_mod_ready = ~bus.i_mod_ready;
                2:       bus.i_mod_ready = 1'b0;
                default: bus.i_mod_ready = 1'b1;
            endcase
        end
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every emitted symbol must match the next expected one; idle data must be zero.
    always @(negedge clk) begin
        if (xrst) begin
            if (bus.o_sym_val) begin
                checkOutput("sym_expected_pending", 16'(expQ.size() > 0), 16'd1);
                if (expQ.size() > 0) begin
                    checkOutput("sym_data", 16'(bus.o_sym_data), 16'(expQ.pop_front()));
                end
            end else begin
                checkOutput("sym_data_idle_zero", 16'(bus.o_sym_data), 16'd0);
            end
        end
    end

    function automatic int bpsOf(input logic [2:0] q);
        case (q)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            3'd3:    return 6;
            default: return 8;
        endcase
    endfunction

    // Start a frame; entered and left one time unit after a rising edge.
    task automatic startFrame(input logic [2:0] q, input logic gray);
        bus.i_start         = 1'b1;
        bus.i_conf_qam_num  = q;
        bus.i_conf_qam_gray = gray;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        if (q <= 3'd4) curBps = bpsOf(q);
        mBits.delete();
    endtask

    // Feed one byte to the model and then hand it to the DUT.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        logic [7:0] s;
        bit accepted;
        for (int i = 7; i >= 0; i--) mBits.push_back(data[i]);
        while (mBits.size() >= curBps) begin
            s = 8'd0;
            for (int k = 0; k < curBps; k++) s = {s[6:0], mBits.pop_front()};
            expQ.push_back(s);
        end
        if (last) begin
            if (mBits.size() > 0) begin
`ifdef QAM_SYM_FEED_PAD_EN
                s = 8'd0;
                for (int k = 0; k < curBps; k++) s = {s[6:0], (mBits.size() > 0) ? mBits.pop_front() : 1'b0};
                expQ.push_back(s);
`endif
                mBits.delete();
            end
        end
        bus.i_byte_data = data;
        bus.i_byte_last = last;
        bus.i_byte_val  = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (bus.o_byte_ready) accepted = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        checkOutput("byte_accepted", 16'(accepted), 16'd1);
        if (last) begin
            bus.i_byte_val  = 1'b0;
            bus.i_byte_last = 1'b0;
        end
    endtask

    // Wait (bounded) for the end-of-frame pulse and check what goes with it.
    task automatic waitFrameDone(input logic expErr);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.o_frame_done) begin
                found = 1'b1;
                checkOutput("frame_done_err", 16'(bus.o_err), 16'(expErr));
            end
            @(posedge clk);
            #1;
        end
        checkOutput("frame_done_seen", 16'(found), 16'd1);
        @(negedge clk);
        checkOutput("after_done_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("after_done_pulse", 16'(bus.o_frame_done), 16'd0);
        checkOutput("after_done_err", 16'(bus.o_err), 16'd0);
        checkOutput("after_done_queue_empty", 16'(expQ.size()), 16'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed sequence of frames following the block's test plan.
    initial begin
        xrst                = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_conf_qam_num  = 3'd0;
        bus.i_conf_qam_gray = 1'b0;
        bus.i_byte_data     = 8'd0;
        bus.i_byte_val      = 1'b0;
        bus.i_byte_last     = 1'b0;

        #3;
        checkOutput("reset_sym_val", 16'(bus.o_sym_val), 16'd0);
        checkOutput("reset_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("reset_byte_ready", 16'(bus.o_byte_ready), 16'd0);
        checkOutput("reset_conf", 16'({bus.o_conf_qam_num, bus.o_conf_qam_gray}), 16'd0);
        #9;
        xrst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] QPSK single byte 0xB4");
        startFrame(3'd1, 1'b1);
        checkOutput("qpsk_busy", 16'(bus.o_busy), 16'd1);
        checkOutput("qpsk_conf_num", 16'(bus.o_conf_qam_num), 16'd1);
        checkOutput("qpsk_conf_gray", 16'(bus.o_conf_qam_gray), 16'd1);
        applyStimulus(8'hB4, 1'b1);
        waitFrameDone(1'b0);

        $display("[TB] QAM64 0xFF, 0x00 with residual bits");
        startFrame(3'd3, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b1);
`ifdef QAM_SYM_FEED_PAD_EN
        waitFrameDone(1'b0);
`else
        waitFrameDone(1'b1);
`endif

        $display("[TB] QAM16 four bytes, toggling downstream ready");
        modMode = 1;
        stalls  = 0;
        startFrame(3'd2, 1'b0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h78, 1'b1);
        waitFrameDone(1'b0);
        checkOutput("qam16_ready_dropped", 16'(stalls > 0), 16'd1);
        modMode = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] BPSK 0x81 with config change mid-frame");
        startFrame(3'd0, 1'b0);
        bus.i_conf_qam_num  = 3'd3;
        bus.i_conf_qam_gray = 1'b1;
        applyStimulus(8'h81, 1'b1);
        @(negedge clk);
        checkOutput("bpsk_conf_held", 16'({bus.o_conf_qam_num, bus.o_conf_qam_gray}), 16'd0);
        @(posedge clk);
        #1;
        waitFrameDone(1'b0);
        checkOutput("bpsk_conf_retained", 16'(bus.o_conf_qam_num), 16'd0);

        $display("[TB] Illegal start qam_num=5");
        startFrame(3'd5, 1'b1);
        @(negedge clk);
        checkOutput("bad_start_err", 16'(bus.o_err), 16'd1);
        checkOutput("bad_start_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("bad_start_byte_ready", 16'(bus.o_byte_ready), 16'd0);
        checkOutput("bad_start_conf_kept", 16'({bus.o_conf_qam_num, bus.o_conf_qam_gray}), 16'd0);
        @(negedge clk);
        checkOutput("bad_start_err_one_cycle", 16'(bus.o_err), 16'd0);
        @(posedge clk);
        #1;

        $display("[TB] QAM256 reset mid-frame");
        modMode = 2;
        repeat (2) @(posedge clk);
        #1;
        startFrame(3'd4, 1'b1);
        applyStimulus(8'hA5, 1'b0);
        bus.i_byte_val = 1'b0;
        #2;
        checkOutput("pre_reset_busy", 16'(bus.o_busy), 16'd1);
        xrst = 1'b0;
        #1;
        checkOutput("async_reset_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("async_reset_sym", 16'({bus.o_sym_val, bus.o_sym_data}), 16'd0);
        checkOutput("async_reset_flags", 16'({bus.o_frame_done, bus.o_err, bus.o_byte_ready}), 16'd0);
        checkOutput("async_reset_conf", 16'({bus.o_conf_qam_num, bus.o_conf_qam_gray}), 16'd0);
        expQ.delete();
        mBits.delete();
        modMode = 0;
        @(negedge clk);
        #2;
        xrst = 1'b1;
        @(posedge clk);
        #1;
        startFrame(3'd4, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(8'hC3, 1'b1);
        waitFrameDone(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
